// File: rtl/fft_ser_pkg.sv
// Shared constants for the FFT-lane serializer scheduler: FSM encoding and
// default geometry of frames, words and the RUN watchdog.
package fft_ser_pkg;

  localparam int FRAME_W_DEF = 256;
  localparam int WORD_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 64;
  localparam int CNT_W_DEF   = 16;

  localparam int ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_START = 2'd1;
  localparam logic [ST_W-1:0] ST_RUN   = 2'd2;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the pointer names the source that wins
// a tie and is kept by the caller.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  always_comb begin
    gnt_id = 1'b0;
    if (req == 2'b11) begin
      gnt_id = ptr;
    end else if (req[1]) begin
      gnt_id = 1'b1;
    end
    gnt = 2'b00;
    if (req != 2'b00) begin
      gnt = gnt_id ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/ser_frame_scheduler.sv
// Shares one serializer between two frame producers: round-robin accept,
// start pulse, beat accounting at done and a RUN-state watchdog.
module ser_frame_scheduler
  import fft_ser_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int WORD_W  = WORD_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FRAME_W-1:0] src0_frame,
  input  logic               src0_valid,
  output logic               src0_ready,
  input  logic [FRAME_W-1:0] src1_frame,
  input  logic               src1_valid,
  output logic               src1_ready,
  output logic               ser_start,
  output logic [FRAME_W-1:0] ser_data,
  output logic               ser_src,
  input  logic               ser_valid,
  input  logic               ser_done,
  output logic               busy,
  output logic [CNT_W-1:0]   frames_done,
  output logic               err_timeout,
  output logic               err_beats,
  input  logic               clear_err
);

  localparam int WORDS  = FRAME_W / WORD_W;
  localparam int TMR_W  = $clog2(TIMEOUT) + 1;
  localparam int BEAT_W = $clog2(TIMEOUT + 1) + 1;
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [BEAT_W-1:0] BEATS_OK = BEAT_W'(WORDS);

  logic [ST_W-1:0]    state_q, state_d;
  logic               rr_q, rr_d;
  logic [FRAME_W-1:0] data_q, data_d;
  logic               src_q, src_d;
  logic [BEAT_W-1:0]  beat_q, beat_d, beat_now;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]   frames_q, frames_d;
  logic               err_to_q, err_to_d;
  logic               err_bt_q, err_bt_d;
  logic [1:0]         gnt;
  logic               gnt_id;

  rr_arb2 u_arb (
    .req    ({src1_valid, src0_valid}),
    .ptr    (rr_q),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // A ser_valid arriving together with ser_done still counts toward the frame.
  assign beat_now = beat_q + BEAT_W'(ser_valid);

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    data_d   = data_q;
    src_d    = src_q;
    beat_d   = beat_q;
    timer_d  = timer_q;
    frames_d = frames_q;
    err_to_d = clear_err ? 1'b0 : err_to_q;
    err_bt_d = clear_err ? 1'b0 : err_bt_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          data_d  = gnt_id ? src1_frame : src0_frame;
          src_d   = gnt_id;
          state_d = ST_START;
        end
      end
      ST_START: begin
        beat_d  = '0;
        timer_d = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        beat_d  = beat_now;
        timer_d = timer_q + TMR_W'(1);
        // Done takes priority over a watchdog expiry in the same cycle.
        if (ser_done) begin
          if (beat_now == BEATS_OK) begin
            frames_d = frames_q + CNT_W'(1);
          end else begin
            err_bt_d = 1'b1;
          end
          rr_d    = ~src_q;
          state_d = ST_IDLE;
        end else if (timer_q == TMR_LAST) begin
          err_to_d = 1'b1;
          rr_d     = ~src_q;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rr_q     <= 1'b0;
      data_q   <= '0;
      src_q    <= 1'b0;
      beat_q   <= '0;
      timer_q  <= '0;
      frames_q <= '0;
      err_to_q <= 1'b0;
      err_bt_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      data_q   <= data_d;
      src_q    <= src_d;
      beat_q   <= beat_d;
      timer_q  <= timer_d;
      frames_q <= frames_d;
      err_to_q <= err_to_d;
      err_bt_q <= err_bt_d;
    end
  end

  assign src0_ready  = (state_q == ST_IDLE) && !reset && gnt[0];
  assign src1_ready  = (state_q == ST_IDLE) && !reset && gnt[1];
  assign ser_start   = (state_q == ST_START);
  assign busy        = (state_q == ST_START) || (state_q == ST_RUN);
  assign ser_data    = data_q;
  assign ser_src     = src_q;
  assign frames_done = frames_q;
  assign err_timeout = err_to_q;
  assign err_beats   = err_bt_q;

endmodule

// File: tb/tb_ser_frame_scheduler.sv
// Bench for ser_frame_scheduler: a behavioural serializer drives ser_valid and
// ser_done, and a frame-level model predicts grants, counts and error flags.
module tb_ser_frame_scheduler;

  localparam int FRAME_W = 256;
  localparam int WORD_W  = 16;
  localparam int CNT_W   = 16;
  localparam logic [FRAME_W-1:0] PAT0 = {4{64'h0123456789ABCDEF}};
  localparam logic [FRAME_W-1:0] PAT1 = {4{64'hFEDCBA9876543210}};

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [FRAME_W-1:0] src0_frame = '0;
  logic               src0_valid = 1'b0;
  logic               src0_ready;
  logic [FRAME_W-1:0] src1_frame = '0;
  logic               src1_valid = 1'b0;
  logic               src1_ready;
  logic               ser_start;
  logic [FRAME_W-1:0] ser_data;
  logic               ser_src;
  logic               ser_valid = 1'b0;
  logic               ser_done = 1'b0;
  logic               busy;
  logic [CNT_W-1:0]   frames_done;
  logic               err_timeout;
  logic               err_beats;
  logic               clear_err = 1'b0;

  always #5 clk = ~clk;

  ser_frame_scheduler dut (
    .clk(clk), .reset(reset),
    .src0_frame(src0_frame), .src0_valid(src0_valid), .src0_ready(src0_ready),
    .src1_frame(src1_frame), .src1_valid(src1_valid), .src1_ready(src1_ready),
    .ser_start(ser_start), .ser_data(ser_data), .ser_src(ser_src),
    .ser_valid(ser_valid), .ser_done(ser_done), .busy(busy),
    .frames_done(frames_done), .err_timeout(err_timeout), .err_beats(err_beats),
    .clear_err(clear_err)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Frame-level reference: tie pointer, completed count and sticky errors.
  bit mPtr = 1'b0;
  int mFrames = 0;
  bit mErrT = 1'b0;
  bit mErrB = 1'b0;

  // Serializer behaviour: smDoneMode 0 = done with last valid, 1 = done one
  // cycle after last valid, 2 = never done.
  int smBeats = 16;
  int smDoneMode = 0;
  bit smGaps = 1'b0;
  int smGapBudget = 0;
  bit smArmed = 1'b0;
  bit smActive = 1'b0;
  bit smPendDone = 1'b0;
  int smSent = 0;
  logic [FRAME_W-1:0] smFrame = '0;
  logic [WORD_W-1:0] smWords[$];

  always @(negedge clk or posedge reset) begin
    if (reset) begin
      ser_valid = 1'b0;
      ser_done = 1'b0;
      smArmed = 1'b0;
      smActive = 1'b0;
      smPendDone = 1'b0;
    end else begin
      ser_valid = 1'b0;
      ser_done = 1'b0;
      if (smArmed) begin
        smArmed = 1'b0;
        smActive = 1'b1;
        smSent = 0;
        smPendDone = 1'b0;
        smGapBudget = 10;
        smWords.delete();
      end
      if (smActive) begin
        if (smPendDone) begin
          ser_done = 1'b1;
          smActive = 1'b0;
          smPendDone = 1'b0;
        end else if (smSent < smBeats) begin
          if (smGaps && smGapBudget > 0 && $urandom_range(0, 3) == 0) begin
            smGapBudget--;
          end else begin
            ser_valid = 1'b1;
            smWords.push_back(smFrame[FRAME_W-1-WORD_W*smSent -: WORD_W]);
            smSent++;
            if (smSent == smBeats) begin
              if (smDoneMode == 0) begin
                ser_done = 1'b1;
                smActive = 1'b0;
              end else if (smDoneMode == 1) begin
                smPendDone = 1'b1;
              end
            end
          end
        end
      end
      if (ser_start) begin
        smArmed = 1'b1;
        smFrame = ser_data;
      end
    end
  end

  function automatic bit mGrant(input bit v0, input bit v1);
    return (v0 && v1) ? mPtr : v1;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
    cyc++;
  endtask

  task automatic applyReset();
    src0_valid = 1'b0;
    src1_valid = 1'b0;
    clear_err = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    mPtr = 1'b0;
    mFrames = 0;
    mErrT = 1'b0;
    mErrB = 1'b0;
  endtask

  task automatic waitIdle(input int maxCycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxCycles; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    src0_valid = 1'b1;
    src1_valid = 1'b1;
    reset = 1'b1;
    tick();
    tests++; if (src0_ready !== 1'b0) begin fails++; $display("[TB] FAIL rst_ready0: got %b expected 0", src0_ready); end
    tests++; if (src1_ready !== 1'b0) begin fails++; $display("[TB] FAIL rst_ready1: got %b expected 0", src1_ready); end
    tests++; if (ser_start !== 1'b0) begin fails++; $display("[TB] FAIL rst_start: got %b expected 0", ser_start); end
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
    tests++; if (ser_src !== 1'b0) begin fails++; $display("[TB] FAIL rst_src: got %b expected 0", ser_src); end
    tests++; if (ser_data !== '0) begin fails++; $display("[TB] FAIL rst_data: got %h expected 0", ser_data); end
    tests++; if (frames_done !== '0) begin fails++; $display("[TB] FAIL rst_frames: got %0d expected 0", frames_done); end
    tests++; if (err_timeout !== 1'b0 || err_beats !== 1'b0) begin fails++; $display("[TB] FAIL rst_errs: got %b%b expected 00", err_timeout, err_beats); end
    src0_valid = 1'b0;
    src1_valid = 1'b0;
    reset = 1'b0;
    tick();
    mPtr = 1'b0; mFrames = 0; mErrT = 1'b0; mErrB = 1'b0;
  endtask

  task automatic test_single();
    logic [WORD_W-1:0] expWords[4];
    bit ok;
    int starts;
    expWords[0] = 16'h0123; expWords[1] = 16'h4567; expWords[2] = 16'h89AB; expWords[3] = 16'hCDEF;
    smBeats = 16; smDoneMode = 0; smGaps = 1'b0;
    src0_frame = PAT0;
    src0_valid = 1'b1;
    #1;
    tests++; if ({src1_ready, src0_ready} !== 2'b01) begin fails++; $display("[TB] FAIL single_ready: got %b expected 01", {src1_ready, src0_ready}); end
    tick();
    src0_valid = 1'b0;
    tests++; if (ser_start !== 1'b1) begin fails++; $display("[TB] FAIL single_start: got %b expected 1", ser_start); end
    tests++; if (ser_data !== PAT0 || ser_src !== 1'b0) begin fails++; $display("[TB] FAIL single_data: got %h/%b expected %h/0", ser_data, ser_src, PAT0); end
    starts = 0;
    tick();
    for (int i = 0; i < 40 && busy; i++) begin
      if (ser_start) starts++;
      tick();
    end
    tests++; if (starts != 0) begin fails++; $display("[TB] FAIL single_start_once: got %0d extra pulses expected 0", starts); end
    waitIdle(60, ok);
    tests++; if (!ok) begin fails++; $display("[TB] FAIL single_idle: got busy expected idle"); end
    tests++; if (smWords.size() != 16) begin fails++; $display("[TB] FAIL single_beats: got %0d expected 16", smWords.size()); end
    for (int i = 0; i < smWords.size(); i++) begin
      tests++; if (smWords[i] !== expWords[i % 4]) begin fails++; $display("[TB] FAIL single_word%0d: got %h expected %h", i, smWords[i], expWords[i % 4]); end
    end
    mFrames++; mPtr = 1'b1;
    tests++; if (frames_done !== CNT_W'(mFrames)) begin fails++; $display("[TB] FAIL single_frames: got %0d expected %0d", frames_done, mFrames); end
    tests++; if (ser_src !== 1'b0 || err_timeout !== 1'b0 || err_beats !== 1'b0) begin fails++; $display("[TB] FAIL single_flags: got src%b errs%b%b expected src0 errs00", ser_src, err_timeout, err_beats); end
  endtask

  task automatic test_contention();
    int accepts, starts;
    bit owner;
    bit ok;
    applyReset();
    smBeats = 16; smDoneMode = 0; smGaps = 1'b0;
    src0_frame = PAT0; src1_frame = PAT1;
    src0_valid = 1'b1; src1_valid = 1'b1;
    accepts = 0; starts = 0; owner = 1'b0;
    for (int c = 0; c < 200 && starts < 4; c++) begin
      #1;
      if (src0_ready || src1_ready) begin
        tests++; if ({src1_ready, src0_ready} !== (accepts[0] ? 2'b10 : 2'b01)) begin fails++; $display("[TB] FAIL cont_grant%0d: got %b expected %b", accepts, {src1_ready, src0_ready}, accepts[0] ? 2'b10 : 2'b01); end
        owner = mGrant(1'b1, 1'b1);
        mPtr = ~owner;
        mFrames++;
        accepts++;
      end
      if (ser_start) begin
        tests++; if (ser_data !== (owner ? PAT1 : PAT0) || ser_src !== owner) begin fails++; $display("[TB] FAIL cont_data%0d: got %h/%b expected %h/%b", starts, ser_data, ser_src, owner ? PAT1 : PAT0, owner); end
        starts++;
      end
      tick();
      if (accepts == 4) begin
        src0_valid = 1'b0; src1_valid = 1'b0;
      end
    end
    src0_valid = 1'b0; src1_valid = 1'b0;
    tests++; if (starts != 4) begin fails++; $display("[TB] FAIL cont_starts: got %0d expected 4", starts); end
    waitIdle(60, ok);
    tests++; if (!ok || frames_done !== 16'd4) begin fails++; $display("[TB] FAIL cont_frames: got %0d idle%b expected 4 idle1", frames_done, ok); end
  endtask

  task automatic test_back_pressure();
    bit ok, sawReady, sawDone;
    applyReset();
    smBeats = 16; smDoneMode = 0; smGaps = 1'b0;
    src0_frame = PAT0; src0_valid = 1'b1;
    tick();
    src0_valid = 1'b0;
    for (int i = 0; i < 20 && smSent < 3; i++) tick();
    src1_frame = PAT1; src1_valid = 1'b1;
    sawReady = 1'b0; sawDone = 1'b0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (src1_ready) sawReady = 1'b1;
      if (ser_done) begin sawDone = 1'b1; break; end
      tick();
    end
    tests++; if (!sawDone || sawReady) begin fails++; $display("[TB] FAIL bp_hold: got done%b ready_seen%b expected done1 ready_seen0", sawDone, sawReady); end
    tick();
    tests++; if (src1_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("[TB] FAIL bp_accept: got ready%b busy%b expected ready1 busy0", src1_ready, busy); end
    tick();
    src1_valid = 1'b0;
    tests++; if (ser_start !== 1'b1 || ser_src !== 1'b1 || ser_data !== PAT1) begin fails++; $display("[TB] FAIL bp_start: got start%b src%b data %h expected start1 src1 data %h", ser_start, ser_src, ser_data, PAT1); end
    mFrames = 2; mPtr = 1'b0;
    tick();
    waitIdle(60, ok);
    tests++; if (!ok || frames_done !== CNT_W'(mFrames)) begin fails++; $display("[TB] FAIL bp_frames: got %0d expected %0d", frames_done, mFrames); end
  endtask

  task automatic test_timeout();
    int t0, dt;
    bit accepted;
    smBeats = 16; smDoneMode = 2; smGaps = 1'b0;
    src0_frame = PAT0; src0_valid = 1'b1;
    accepted = 1'b0; t0 = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (src0_ready) begin accepted = 1'b1; t0 = cyc; break; end
      tick();
    end
    tests++; if (!accepted) begin fails++; $display("[TB] FAIL to_accept: got no ready expected ready"); end
    tick();
    src0_valid = 1'b0;
    dt = -1;
    for (int i = 0; i < 100; i++) begin
      if (err_timeout) begin dt = cyc - t0; break; end
      tick();
    end
    tests++; if (dt != 66) begin fails++; $display("[TB] FAIL to_latency: got %0d cycles after accept expected 66", dt); end
    tests++; if (busy !== 1'b0 || frames_done !== CNT_W'(mFrames)) begin fails++; $display("[TB] FAIL to_state: got busy%b frames%0d expected busy0 frames%0d", busy, frames_done, mFrames); end
    mPtr = 1'b1;
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    tests++; if (err_timeout !== 1'b0) begin fails++; $display("[TB] FAIL to_clear: got %b expected 0", err_timeout); end
    smDoneMode = 0;
  endtask

  task automatic runFrame(input logic [FRAME_W-1:0] f, output bit ok);
    src0_frame = f; src0_valid = 1'b1;
    tick();
    src0_valid = 1'b0;
    tick();
    waitIdle(80, ok);
  endtask

  task automatic test_beats();
    bit ok, sawDone;
    smBeats = 15; smDoneMode = 1; smGaps = 1'b0;
    runFrame(PAT1, ok);
    tests++; if (!ok || err_beats !== 1'b1 || frames_done !== CNT_W'(mFrames)) begin fails++; $display("[TB] FAIL beats_short: got err%b frames%0d expected err1 frames%0d", err_beats, frames_done, mFrames); end
    clear_err = 1'b1;
    src0_frame = PAT0; src0_valid = 1'b1;
    tick();
    src0_valid = 1'b0;
    tests++; if (err_beats !== 1'b0) begin fails++; $display("[TB] FAIL beats_clear: got %b expected 0", err_beats); end
    sawDone = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (ser_done) begin sawDone = 1'b1; break; end
      tick();
    end
    tick();
    clear_err = 1'b0;
    tests++; if (!sawDone || err_beats !== 1'b1) begin fails++; $display("[TB] FAIL beats_set_wins: got done%b err%b expected done1 err1", sawDone, err_beats); end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    smBeats = 16; smDoneMode = 0;
    runFrame(PAT0, ok);
    mFrames++;
    tests++; if (!ok || err_beats !== 1'b0 || frames_done !== CNT_W'(mFrames)) begin fails++; $display("[TB] FAIL beats_coincident: got err%b frames%0d expected err0 frames%0d", err_beats, frames_done, mFrames); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    smBeats = 16; smDoneMode = 0; smGaps = 1'b0;
    src1_frame = PAT1; src1_valid = 1'b1;
    tick();
    src1_valid = 1'b0;
    for (int i = 0; i < 30 && smSent < 8; i++) tick();
    #2;
    reset = 1'b1;
    #1;
    tests++; if (busy !== 1'b0 || ser_start !== 1'b0 || ser_src !== 1'b0) begin fails++; $display("[TB] FAIL midrst_ctrl: got busy%b start%b src%b expected 000", busy, ser_start, ser_src); end
    tests++; if (ser_data !== '0 || frames_done !== '0) begin fails++; $display("[TB] FAIL midrst_data: got %h frames%0d expected 0 frames0", ser_data, frames_done); end
    src0_frame = PAT0; src0_valid = 1'b1; src1_valid = 1'b1;
    #1;
    tests++; if ({src1_ready, src0_ready} !== 2'b00) begin fails++; $display("[TB] FAIL midrst_ready: got %b expected 00", {src1_ready, src0_ready}); end
    tick();
    reset = 1'b0;
    mPtr = 1'b0; mFrames = 0; mErrT = 1'b0; mErrB = 1'b0;
    #1;
    tests++; if ({src1_ready, src0_ready} !== 2'b01) begin fails++; $display("[TB] FAIL midrst_grant: got %b expected 01", {src1_ready, src0_ready}); end
    tick();
    src0_valid = 1'b0; src1_valid = 1'b0;
    tests++; if (ser_start !== 1'b1 || ser_data !== PAT0) begin fails++; $display("[TB] FAIL midrst_start: got start%b data %h expected start1 data %h", ser_start, ser_data, PAT0); end
    mPtr = 1'b1; mFrames = 1;
    tick();
    waitIdle(60, ok);
    tests++; if (!ok || frames_done !== CNT_W'(mFrames)) begin fails++; $display("[TB] FAIL midrst_frames: got %0d expected %0d", frames_done, mFrames); end
  endtask

  task automatic test_random();
    int accepts, r;
    bit owner, take0, take1, ok;
    logic [FRAME_W-1:0] expFrame;
    applyReset();
    smGaps = 1'b1;
    accepts = 0; owner = 1'b0; expFrame = '0;
    for (int c = 0; c < 4000 && accepts < 40; c++) begin
      take0 = 1'b0; take1 = 1'b0;
      if (!src0_valid && $urandom_range(0, 1) == 1) begin
        src0_frame = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        src0_valid = 1'b1;
      end
      if (!src1_valid && $urandom_range(0, 1) == 1) begin
        src1_frame = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        src1_valid = 1'b1;
      end
      #1;
      if (src0_ready || src1_ready) begin
        owner = mGrant(src0_valid, src1_valid);
        tests++; if ({src1_ready, src0_ready} !== (owner ? 2'b10 : 2'b01)) begin fails++; $display("[TB] FAIL rnd_grant%0d: got %b expected %b", accepts, {src1_ready, src0_ready}, owner ? 2'b10 : 2'b01); end
        tests++; if (frames_done !== CNT_W'(mFrames) || err_timeout !== mErrT || err_beats !== mErrB) begin fails++; $display("[TB] FAIL rnd_status%0d: got frames%0d errs%b%b expected frames%0d errs%b%b", accepts, frames_done, err_timeout, err_beats, mFrames, mErrT, mErrB); end
        expFrame = owner ? src1_frame : src0_frame;
        r = $urandom_range(0, 9);
        if (r == 0) begin smBeats = 16; smDoneMode = 2; mErrT = 1'b1; end
        else if (r == 1) begin smBeats = 15; smDoneMode = 1; mErrB = 1'b1; end
        else if (r == 2) begin smBeats = 17; smDoneMode = 0; mErrB = 1'b1; end
        else begin smBeats = 16; smDoneMode = $urandom_range(0, 1); mFrames++; end
        mPtr = ~owner;
        take0 = !owner; take1 = owner;
        accepts++;
      end
      if (ser_start) begin
        tests++; if (ser_data !== expFrame || ser_src !== owner) begin fails++; $display("[TB] FAIL rnd_data%0d: got %h/%b expected %h/%b", accepts, ser_data, ser_src, expFrame, owner); end
      end
      tick();
      if (take0) src0_valid = 1'b0;
      if (take1) src1_valid = 1'b0;
      if (accepts == 40) begin src0_valid = 1'b0; src1_valid = 1'b0; end
    end
    tests++; if (accepts != 40) begin fails++; $display("[TB] FAIL rnd_accepts: got %0d expected 40", accepts); end
    tick();
    waitIdle(100, ok);
    tests++; if (!ok || frames_done !== CNT_W'(mFrames) || err_timeout !== mErrT || err_beats !== mErrB) begin fails++; $display("[TB] FAIL rnd_final: got frames%0d errs%b%b expected frames%0d errs%b%b", frames_done, err_timeout, err_beats, mFrames, mErrT, mErrB); end
    smGaps = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_back_pressure();
    test_timeout();
    test_beats();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ser_frame_scheduler.md
Name: ser_frame_scheduler

Overview:
- Shares one serializer instance (256-bit frame in, 16-bit words out) between two frame producers, e.g. FFT lane 0 and lane 1 result buses.
- Round-robin arbitrates, latches the winning frame, and pulses the serializer start.
- Holds the frame stable until serialization_done, then checks the beat count and enforces a timeout watchdog.
- Sits between the FFT output stage and the serializer.

Parameters:
- FRAME_W, 256, frame width in bits.
- WORD_W, 16, serializer output word width.
- WORDS, FRAME_W/WORD_W (16), expected output_valid beats per frame.
- TIMEOUT, 64, maximum cycles in RUN before abort.
- CNT_W, 16, width of the frames_done counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- src0_frame  in  FRAME_W  source 0 frame data.
- src0_valid  in  1  source 0 frame available.
- src0_ready  out  1  source 0 frame accepted this cycle.
- src1_frame  in  FRAME_W  source 1 frame data.
- src1_valid  in  1  source 1 frame available.
- src1_ready  out  1  source 1 frame accepted this cycle.
- ser_start  out  1  one-cycle start pulse to the serializer start_serialize.
- ser_data  out  FRAME_W  latched frame to the serializer input_data.
- ser_src  out  1  owner of the current or last frame (0/1).
- ser_valid  in  1  serializer output_valid.
- ser_done  in  1  serializer serialization_done.
- busy  out  1  high in START or RUN.
- frames_done  out  CNT_W  count of frames completed correctly; wraps.
- err_timeout  out  1  sticky: RUN exceeded TIMEOUT cycles.
- err_beats  out  1  sticky: beat count at done differed from WORDS.
- clear_err  in  1  synchronous clear of both sticky errors.

Behaviour:
- Reset (async, any state):
  - State goes to IDLE.
  - ser_start, busy, ser_src, rr pointer, err flags, counters and ser_data are all 0.
  - src*_ready low while reset is high.
  - An in-flight frame is dropped; the serializer is reset by the same reset.
- States: IDLE, START, RUN.
- IDLE:
  - If any srcN_valid is high, grant per round-robin: if both are valid, take the source equal to the rr pointer; otherwise take the one that is valid.
  - srcN_ready (combinational from state and valids) is high for the granted source only, in this cycle.
  - ser_data <= granted frame; ser_src <= N; go to START.
- Handshake rules:
  - A transfer occurs on valid & ready.
  - Sources hold valid and frame stable until ready.
  - Ready is never high outside IDLE and never high to both sources.
- START:
  - ser_start = 1 for exactly this cycle.
  - Beat counter and timer cleared; go to RUN.
- RUN:
  - Beat counter increments on each ser_valid; timer increments every cycle.
  - On ser_done:
    - The beat count includes a ser_valid in the same cycle.
    - If count == WORDS, frames_done++ (wraps at 2^CNT_W); otherwise set err_beats and do not increment.
    - rr pointer <= ~ser_src; go to IDLE.
  - If the timer reaches TIMEOUT-1 with no ser_done: set err_timeout, rr pointer <= ~ser_src, go to IDLE. The frame is lost and frames_done is unchanged.
- Simultaneous events:
  - ser_done and timeout expiry in the same cycle: done wins, no err_timeout.
  - ser_done or ser_valid in IDLE or START: ignored.
  - clear_err and a new error in the same cycle: set wins.
- ser_data and ser_src hold from the IDLE accept until the next accept.
- Latency:
  - Accept cycle T, ser_start at T+1.
  - After done at cycle D, IDLE at D+1, earliest next accept D+1, next start D+2.
- Fairness: with both sources continuously valid, grants alternate 0,1,0,1… starting with source 0 after reset.

Decomposition:
- Package fft_ser_pkg: state encoding constants (IDLE/START/RUN), default FRAME_W/WORD_W/TIMEOUT.
- Sub-module rr_arb2: 2-request round-robin arbiter.
  - Inputs: req[1:0], ptr.
  - Outputs: gnt[1:0] one-hot, gnt_id.
  - Purely combinational; the pointer register lives in the scheduler.

Test Plan:
- Single source:
  - Stimulus: src0_valid with frame 0123456789ABCDEF×4, real serializer attached.
  - Required: ready for one cycle, ser_start one cycle later, 16 ser_valid beats with words 0123, 4567, 89AB, CDEF…; on done, frames_done=1, ser_src=0, no errors.
- Contention:
  - Stimulus: both sources valid with distinct frames (src0=…CDEF pattern, src1=FEDCBA9876543210×4) held for 4 frames.
  - Required: grant order 0,1,0,1; frames_done=4; each ser_data matches its owner's frame.
- Back-pressure:
  - Stimulus: src1_valid raised during RUN of a src0 frame.
  - Required: src1_ready stays 0 until the IDLE cycle after done; src1 frame starts 2 cycles after done.
- Timeout:
  - Stimulus: serializer model that never asserts done, TIMEOUT=64.
  - Required: err_timeout=1 exactly 64 cycles after entering RUN; return to IDLE; frames_done unchanged; clear_err drops the flag next cycle.
- Beat mismatch:
  - Stimulus: model emitting 15 valids then done.
  - Required: err_beats=1, frames_done unchanged.
  - Variant: done coincident with the 16th valid → counted correctly, no error.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously during RUN of beat 8.
  - Required: all outputs 0 immediately; after release, rr pointer=0 and a new frame is accepted normally.
